// File: rtl/ir_key_dec_if.sv
// Signal bundle between the IR receiver side and the NEC key decoder.
// The receiver side uses the master modport; the decoder uses the slave modport.
interface ir_key_dec_if;
  logic [31:0] i_frame;
  logic        i_frame_vld;
  logic        i_repeat;
  logic        o_key_vld;
  logic [7:0]  o_key;
  logic [7:0]  o_addr;
  logic        o_rpt;
  logic        o_err;
  logic        o_held;
  logic [23:0] o_digits;

  modport master (
    output i_frame, i_frame_vld, i_repeat,
    input  o_key_vld, o_key, o_addr, o_rpt, o_err, o_held, o_digits
  );

  modport slave (
    input  i_frame, i_frame_vld, i_repeat,
    output o_key_vld, o_key, o_addr, o_rpt, o_err, o_held, o_digits
  );
endinterface

// File: rtl/ir_key_dec.sv
// NEC frame validator and key event generator with held-key auto-repeat,
// hold timeout and a three-key history for the six-digit display.
//
// state | meaning
// IDLE  | no key held, waiting for a frame
// CHECK | latched frame is being complement-checked (one cycle)
// HELD  | valid key held; counting repeat codes and idle time
module ir_key_dec #(
  parameter int ADDR_CHK  = 1,
  parameter int RPT_DELAY = 3,
  parameter int RPT_RATE  = 2,
  parameter int HOLD_TO   = 6_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  ir_key_dec_if.slave  bus
);

  localparam int TW = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(HOLD_TO - 1);
  localparam logic [7:0]    DLY_CNT   = 8'(RPT_DELAY);
  localparam logic [7:0]    RATE_CNT  = 8'(RPT_RATE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t        state_q;
  logic [31:0]   frame_q;
  logic          chk_ok_q;
  logic          chk_bad_q;
  logic [7:0]    rpt_n_q;
  logic [7:0]    rate_q;
  logic [TW-1:0] to_cnt_q;

  logic          key_vld_q;
  logic [7:0]    key_q;
  logic [7:0]    addr_q;
  logic          rpt_q;
  logic          err_q;
  logic          held_q;
  logic [23:0]   digits_q;

  logic          pass_d;
  logic [7:0]    rpt_n_d;
  logic          rpt_sat_d;

  always_comb begin
    pass_d = (frame_q[15:8] == ~frame_q[7:0]);
    if (ADDR_CHK != 0) begin
      pass_d = pass_d && (frame_q[31:24] == ~frame_q[23:16]);
    end
    rpt_sat_d = (rpt_n_q == 8'hFF);
    rpt_n_d   = rpt_sat_d ? rpt_n_q : rpt_n_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      chk_ok_q  <= 1'b0;
      chk_bad_q <= 1'b0;
      rpt_n_q   <= '0;
      rate_q    <= '0;
      to_cnt_q  <= '0;
      key_vld_q <= 1'b0;
      key_q     <= '0;
      addr_q    <= '0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      held_q    <= 1'b0;
      digits_q  <= '0;
    end else begin
      key_vld_q <= 1'b0;
      rpt_q     <= 1'b0;
      err_q     <= 1'b0;
      chk_ok_q  <= 1'b0;
      chk_bad_q <= 1'b0;

      // Check result from the previous cycle becomes the registered key event.
      if (chk_ok_q) begin
        key_vld_q <= 1'b1;
        key_q     <= frame_q[15:8];
        addr_q    <= frame_q[31:24];
        held_q    <= 1'b1;
        digits_q  <= {digits_q[15:0], frame_q[15:8]};
        rpt_n_q   <= '0;
        rate_q    <= '0;
        to_cnt_q  <= '0;
      end
      if (chk_bad_q) begin
        err_q  <= 1'b1;
        held_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (bus.i_frame_vld) begin
            frame_q <= bus.i_frame;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (pass_d) begin
            chk_ok_q <= 1'b1;
            state_q  <= HELD;
          end else begin
            chk_bad_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        HELD: begin
          if (bus.i_frame_vld) begin
            frame_q <= bus.i_frame;
            state_q <= CHECK;
          end else if (!chk_ok_q) begin
            if (bus.i_repeat) begin
              to_cnt_q <= '0;
              if (!rpt_sat_d) begin
                rpt_n_q <= rpt_n_d;
                if (rpt_n_d == DLY_CNT) begin
                  key_vld_q <= 1'b1;
                  rpt_q     <= 1'b1;
                  rate_q    <= RATE_CNT;
                end else if (rpt_n_d > DLY_CNT) begin
                  // rate_q counts down the repeats left until the next auto-repeat
                  if (rate_q <= 8'd1) begin
                    key_vld_q <= 1'b1;
                    rpt_q     <= 1'b1;
                    rate_q    <= RATE_CNT;
                  end else begin
                    rate_q <= rate_q - 8'd1;
                  end
                end
              end
            end else if (to_cnt_q == TO_LAST) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_key_vld = key_vld_q;
  assign bus.o_key     = key_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_rpt     = rpt_q;
  assign bus.o_err     = err_q;
  assign bus.o_held    = held_q;
  assign bus.o_digits  = digits_q;

endmodule

// File: tb/tb_ir_key_dec.sv
// Directed bench for ir_key_dec: one instance with address check, one without.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ir_key_dec;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   n_ev;
  int   n_rpt;

  ir_key_dec_if bus0 ();
  ir_key_dec_if bus1 ();

  ir_key_dec #(.ADDR_CHK(1), .RPT_DELAY(3), .RPT_RATE(2), .HOLD_TO(100)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  ir_key_dec #(.ADDR_CHK(0), .RPT_DELAY(3), .RPT_RATE(2), .HOLD_TO(100)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f, input bit to0, input bit to1);
    bus0.i_frame     = f;
    bus1.i_frame     = f;
    bus0.i_frame_vld = to0;
    bus1.i_frame_vld = to1;
    tick(1);
    bus0.i_frame_vld = 1'b0;
    bus1.i_frame_vld = 1'b0;
  endtask

  task automatic pulse_rpt();
    bus0.i_repeat = 1'b1;
    tick(1);
    bus0.i_repeat = 1'b0;
  endtask

  // Send a frame to the checked instance and land on the event cycle.
  task automatic press(input logic [31:0] f);
    send_frame(f, 1'b1, 1'b0);
    tick(2);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus0.i_frame = '0; bus0.i_frame_vld = 1'b0; bus0.i_repeat = 1'b0;
    bus1.i_frame = '0; bus1.i_frame_vld = 1'b0; bus1.i_repeat = 1'b0;
    tick(3);
    chk("rst_ctl", {bus0.o_key_vld, bus0.o_rpt, bus0.o_err, bus0.o_held, bus0.o_key, bus0.o_addr}, 32'h0);
    chk("rst_digits", {8'h0, bus0.o_digits}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // new press: event two cycles after the vld edge
    send_frame(32'h00FF_18E7, 1'b1, 1'b0);
    tick(1);
    chk("press_early", {31'h0, bus0.o_key_vld}, 32'h0);
    tick(1);
    chk("press_vld", {28'h0, bus0.o_key_vld, bus0.o_rpt, bus0.o_err, bus0.o_held}, 32'h9);
    chk("press_key", {16'h0, bus0.o_addr, bus0.o_key}, 32'h0000_0018);
    chk("press_digits", {8'h0, bus0.o_digits}, 32'h0000_0018);
    tick(1);
    chk("press_pulse", {31'h0, bus0.o_key_vld}, 32'h0);

    // auto-repeat after repeats 3, 5, 7
    for (int i = 1; i <= 7; i++) begin
      tick(19);
      pulse_rpt();
      chk($sformatf("rpt%0d_vld", i), {30'h0, bus0.o_key_vld, bus0.o_rpt},
          (i == 3 || i == 5 || i == 7) ? 32'h3 : 32'h0);
    end
    chk("rpt_key", {16'h0, bus0.o_held, 7'h0, bus0.o_key}, 32'h0000_8018);
    chk("rpt_digits", {8'h0, bus0.o_digits}, 32'h0000_0018);

    // hold timeout
    tick(5);
    press(32'h00FF_18E7);
    chk("to_press", {31'h0, bus0.o_held}, 32'h1);
    tick(99);
    chk("to_still_held", {31'h0, bus0.o_held}, 32'h1);
    tick(1);
    chk("to_released", {31'h0, bus0.o_held}, 32'h0);
    pulse_rpt();
    chk("to_rpt_ignored", {30'h0, bus0.o_key_vld, bus0.o_held}, 32'h0);
    tick(3);
    pulse_rpt();
    chk("idle_rpt_ignored", {30'h0, bus0.o_key_vld, bus0.o_held}, 32'h0);

    // complement errors
    tick(3);
    send_frame(32'h00FF_18E6, 1'b1, 1'b0);
    tick(2);
    chk("cmd_err", {29'h0, bus0.o_err, bus0.o_key_vld, bus0.o_held}, 32'h4);
    chk("cmd_err_digits", {8'h0, bus0.o_digits}, 32'h0000_1818);
    tick(1);
    chk("cmd_err_pulse", {31'h0, bus0.o_err}, 32'h0);
    press(32'h00FF_18E7);
    tick(2);
    send_frame(32'h00FF_18E6, 1'b1, 1'b0);
    tick(1);
    chk("held_err_wait", {31'h0, bus0.o_held}, 32'h1);
    tick(1);
    chk("held_err", {29'h0, bus0.o_err, bus0.o_key_vld, bus0.o_held}, 32'h4);
    chk("held_err_key", {24'h0, bus0.o_key}, 32'h18);
    tick(3);
    send_frame(32'h00FE_18E7, 1'b1, 1'b1);
    tick(2);
    chk("addr_err_chk1", {30'h0, bus0.o_err, bus0.o_key_vld}, 32'h2);
    chk("addr_ok_chk0", {30'h0, bus1.o_err, bus1.o_key_vld}, 32'h1);
    chk("addr_ok_chk0_key", {16'h0, bus1.o_addr, bus1.o_key}, 32'h0000_0018);

    // key history
    tick(3);
    press(32'h00FF_18E7);
    press(32'h00FF_5AA5);
    press(32'h00FF_08F7);
    chk("hist_3", {8'h0, bus0.o_digits}, 32'h0018_5A08);
    press(32'h00FF_1CE3);
    chk("hist_4", {8'h0, bus0.o_digits}, 32'h005A_081C);
    chk("hist_4_key", {24'h0, bus0.o_key}, 32'h1C);

    // frame and repeat together while held: frame wins
    tick(3);
    bus0.i_frame     = 32'h00FF_45BA;
    bus0.i_frame_vld = 1'b1;
    bus0.i_repeat    = 1'b1;
    tick(1);
    bus0.i_frame_vld = 1'b0;
    bus0.i_repeat    = 1'b0;
    n_ev  = 0;
    n_rpt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus0.o_key_vld) n_ev++;
      if (bus0.o_rpt) n_rpt++;
      tick(1);
    end
    chk("simul_events", n_ev, 1);
    chk("simul_rpt", n_rpt, 0);
    chk("simul_digits", {8'h0, bus0.o_digits}, 32'h0008_1C45);

    // asynchronous reset while held
    chk("pre_rst_held", {31'h0, bus0.o_held}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {bus0.o_key_vld, bus0.o_rpt, bus0.o_err, bus0.o_held, bus0.o_key, bus0.o_addr}, 32'h0);
    chk("arst_digits", {8'h0, bus0.o_digits}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    press(32'h00FF_18E7);
    chk("post_rst_vld", {28'h0, bus0.o_key_vld, bus0.o_rpt, bus0.o_err, bus0.o_held}, 32'h9);
    chk("post_rst_digits", {8'h0, bus0.o_digits}, 32'h0000_0018);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
